// File: rtl/hit_window_scheduler.sv
// Rhythm Hero note sequencer: gap, timed hit window, verdict per slot.
// Keeps a saturating score and streak across one pattern run.
module hit_window_scheduler #(
    parameter int WINDOW_CYCLES = 50000000,
    parameter int GAP_CYCLES    = 25000000,
    parameter int PATTERN_LEN   = 16,
    parameter int SCORE_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [3:0]                     buttons,
    output logic [$clog2(PATTERN_LEN)-1:0] pattern_idx,
    input  logic [3:0]                     pattern_lane,
    output logic [3:0]                     lane_active,
    output logic                           hit,
    output logic                           miss,
    output logic [SCORE_W-1:0]             score,
    output logic [SCORE_W-1:0]             streak,
    output logic                           busy,
    output logic                           done
);

    localparam int IDX_W = $clog2(PATTERN_LEN);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        ARMED,
        JUDGE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [3:0]         lane_q, lane_d;
    logic               vhit_q, vhit_d;
    logic               vmiss_q, vmiss_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] streak_q, streak_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            win_q    <= '0;
            lane_q   <= '0;
            vhit_q   <= 1'b0;
            vmiss_q  <= 1'b0;
            score_q  <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            win_q    <= win_d;
            lane_q   <= lane_d;
            vhit_q   <= vhit_d;
            vmiss_q  <= vmiss_d;
            score_q  <= score_d;
            streak_q <= streak_d;
        end
    end

    // Next-state logic: sequencing, window timing and verdict scoring.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        win_d    = win_q;
        lane_d   = lane_q;
        vhit_d   = vhit_q;
        vmiss_d  = vmiss_q;
        score_d  = score_q;
        streak_d = streak_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = GAP;
                    idx_d    = '0;
                    gap_d    = '0;
                    win_d    = '0;
                    score_d  = '0;
                    streak_d = '0;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    vhit_d  = 1'b0;
                    vmiss_d = 1'b0;
                    if (pattern_lane == 4'b0000) begin
                        state_d = JUDGE;
                    end else begin
                        state_d = ARMED;
                        lane_d  = pattern_lane;
                        win_d   = '0;
                    end
                end
            end
            ARMED: begin
                win_d = win_q + 1'b1;
                // A press on the timeout cycle wins over the timeout.
                if (buttons != 4'b0000) begin
                    state_d = JUDGE;
                    lane_d  = '0;
                    vhit_d  = (buttons == lane_q);
                    vmiss_d = (buttons != lane_q);
                end else if (win_q == WIN_LAST) begin
                    state_d = JUDGE;
                    lane_d  = '0;
                    vhit_d  = 1'b0;
                    vmiss_d = 1'b1;
                end
            end
            JUDGE: begin
                if (vhit_q) begin
                    if (score_q != '1) begin
                        score_d = score_q + 1'b1;
                    end
                    if (streak_q != '1) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
                if (vmiss_q) begin
                    streak_d = '0;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = GAP;
                    idx_d   = idx_q + 1'b1;
                    gap_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pattern_idx = idx_q;
    assign lane_active = lane_q;
    assign hit         = (state_q == JUDGE) && vhit_q;
    assign miss        = (state_q == JUDGE) && vmiss_q;
    assign score       = score_q;
    assign streak      = streak_q;
    assign busy        = (state_q == GAP) || (state_q == ARMED)
                      || (state_q == JUDGE);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_hit_window_scheduler.sv
// Directed bench for hit_window_scheduler (4-slot and 20-slot instances).
// Expected values are hand-derived from the window/gap timing.
module tb_hit_window_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] buttons = 4'b0;
    logic [1:0] pattern_idx;
    logic [3:0] pattern_lane;
    logic [3:0] lane_active;
    logic       hit, miss, busy, done;
    logic [3:0] score, streak;

    logic       start2 = 1'b0;
    logic [3:0] buttons2 = 4'b0;
    logic [4:0] idx2;
    logic [3:0] lane_active2;
    logic       hit2, miss2, busy2, done2;
    logic [3:0] score2, streak2;

    logic [3:0] rom [4];
    int n_vec = 0;
    int n_bad = 0;

    assign pattern_lane = rom[pattern_idx];

    always #5 clk = ~clk;

    hit_window_scheduler #(
        .WINDOW_CYCLES(8), .GAP_CYCLES(4),
        .PATTERN_LEN(4), .SCORE_W(4)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .buttons(buttons),
        .pattern_idx(pattern_idx), .pattern_lane(pattern_lane),
        .lane_active(lane_active), .hit(hit), .miss(miss),
        .score(score), .streak(streak), .busy(busy), .done(done)
    );

    hit_window_scheduler #(
        .WINDOW_CYCLES(8), .GAP_CYCLES(4),
        .PATTERN_LEN(20), .SCORE_W(4)
    ) u_dut20 (
        .clk(clk), .rst(rst), .start(start2), .buttons(buttons2),
        .pattern_idx(idx2), .pattern_lane(4'b0001),
        .lane_active(lane_active2), .hit(hit2), .miss(miss2),
        .score(score2), .streak(streak2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_armed(input string tag);
        int n = 0;
        while (lane_active == 4'b0 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_open"}, 32'(lane_active != 4'b0), 1);
    endtask

    // Wait for the window, press after d cycles, check the pulse.
    task automatic press_slot(input string tag, input int d,
                              input logic [3:0] b, input logic exp_hit);
        wait_armed(tag);
        repeat (d) tick();
        buttons = b;
        tick();
        buttons = 4'b0;
        check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        check({tag, "_miss"}, 32'(miss), 32'(!exp_hit));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seq_bad;
        int rest_bad;
        int misses;
        int hits;
        logic [1:0] prev;

        // Reset state
        do_reset();
        check("rst_idx", 32'(pattern_idx), 0);
        check("rst_lane", 32'(lane_active), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_score", 32'(score), 0);
        check("rst_pulse", 32'(hit | miss), 0);

        // Correct hits on every lane
        rom[0] = 4'b0001; rom[1] = 4'b0010;
        rom[2] = 4'b0100; rom[3] = 4'b1000;
        pulse_start();
        n = 1;
        while (lane_active == 4'b0 && n < 50) begin
            tick();
            n++;
        end
        check("latency", n, 5);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_armed("t1");
            check("t1_lane", 32'(lane_active), 32'(rom[i]));
            repeat (3) tick();
            buttons = lane_active;
            tick();
            buttons = 4'b0;
            check("t1_hit", 32'(hit), 1);
            check("t1_miss", 32'(miss), 0);
            check("t1_lane_off", 32'(lane_active), 0);
            tick();
            check("t1_score", 32'(score), i + 1);
            check("t1_streak", 32'(streak), i + 1);
        end
        check("t1_done", 32'(done), 1);
        check("t1_busy", 32'(busy), 0);
        check("t1_idx", 32'(pattern_idx), 3);

        // Timeout, restarting from DONE
        rom[0] = 4'b0010; rom[1] = 4'b0010;
        rom[2] = 4'b0010; rom[3] = 4'b0010;
        pulse_start();
        check("t2_restart_score", 32'(score), 0);
        wait_armed("t2");
        n = 0;
        while (lane_active == 4'b0010 && n < 20) begin
            n++;
            tick();
        end
        check("t2_window_len", n, 8);
        check("t2_miss", 32'(miss), 1);
        check("t2_hit", 32'(hit), 0);
        tick();
        check("t2_score", 32'(score), 0);
        do_reset();

        // Wrong lane, two buttons, press on timeout cycle, gap press
        rom[0] = 4'b0001; rom[1] = 4'b0001;
        rom[2] = 4'b0010; rom[3] = 4'b0100;
        pulse_start();
        press_slot("t3_s0", 0, 4'b0001, 1'b1);
        check("t3_streak1", 32'(streak), 1);
        press_slot("t3_wrong", 2, 4'b0010, 1'b0);
        check("t3_streak0", 32'(streak), 0);
        check("t3_score1", 32'(score), 1);
        press_slot("t3_multi", 1, 4'b0011, 1'b0);
        check("t3_in_gap", 32'(busy && lane_active == 4'b0), 1);
        buttons = 4'b0100;
        tick();
        buttons = 4'b0;
        check("t3_gap_pulse", 32'(hit | miss), 0);
        tick();
        buttons = 4'b0100;
        tick();
        buttons = 4'b0;
        check("t3_gap_pulse2", 32'(hit | miss), 0);
        press_slot("t3_late", 7, 4'b0100, 1'b1);
        check("t3_score", 32'(score), 2);
        check("t3_streak", 32'(streak), 1);
        check("t3_done", 32'(done), 1);

        // Rest slot, run length with no presses
        rom[0] = 4'b0001; rom[1] = 4'b0000;
        rom[2] = 4'b0001; rom[3] = 4'b0001;
        pulse_start();
        n = 0; seq_bad = 0; rest_bad = 0;
        misses = 0; hits = 0; prev = 2'd0;
        while (busy && n < 200) begin
            if (pattern_idx != prev) begin
                if (pattern_idx != prev + 2'd1) seq_bad++;
                prev = pattern_idx;
            end
            if (pattern_idx == 2'd1 && (hit || miss || lane_active != 0))
                rest_bad++;
            if (miss) misses++;
            if (hit) hits++;
            n++;
            tick();
        end
        check("t4_run_len", n, 44);
        check("t4_idx_seq", seq_bad, 0);
        check("t4_idx_last", 32'(prev), 3);
        check("t4_rest_quiet", rest_bad, 0);
        check("t4_misses", misses, 3);
        check("t4_hits", hits, 0);

        // start while busy, reset mid-window, start from DONE
        rom[0] = 4'b0001; rom[1] = 4'b0001;
        rom[2] = 4'b0001; rom[3] = 4'b0001;
        pulse_start();
        press_slot("t5_s0", 0, 4'b0001, 1'b1);
        pulse_start();
        check("t5_busy_start_idx", 32'(pattern_idx), 1);
        check("t5_busy_start_score", 32'(score), 1);
        press_slot("t5_s1", 1, 4'b0001, 1'b1);
        wait_armed("t5_s2");
        tick();
        tick();
        check("t5_mid_idx", 32'(pattern_idx), 2);
        rst = 1'b1;
        buttons = 4'b0001;
        tick();
        rst = 1'b0;
        buttons = 4'b0;
        check("t5_rst_lane", 32'(lane_active), 0);
        check("t5_rst_pulse", 32'(hit | miss), 0);
        check("t5_rst_idx", 32'(pattern_idx), 0);
        check("t5_rst_score", 32'(score + streak), 0);
        check("t5_rst_flags", 32'({busy, done}), 0);
        tick();
        check("t5_idle_pulse", 32'(hit | miss | busy), 0);
        pulse_start();
        for (int i = 0; i < 4; i++) press_slot("t5_run", 0, 4'b0001, 1'b1);
        check("t5_done_score", 32'(score), 4);
        pulse_start();
        check("t5_re_score", 32'(score), 0);
        check("t5_re_streak", 32'(streak), 0);
        check("t5_re_idx", 32'(pattern_idx), 0);
        check("t5_re_flags", 32'({busy, done}), 2);

        // Saturation on the 20-slot instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (lane_active2 == 4'b0 && n < 100) begin
                tick();
                n++;
            end
            buttons2 = 4'b0001;
            tick();
            buttons2 = 4'b0;
            tick();
            if (i == 13) check("t6_score14", 32'(score2), 14);
        end
        check("t6_done", 32'(done2), 1);
        check("t6_idx", 32'(idx2), 19);
        check("t6_score_sat", 32'(score2), 15);
        check("t6_streak_sat", 32'(streak2), 15);
        check("t6_no_miss", 32'(miss2 | busy2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
